mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Consumer end of the execute-stage interface. Captures execute results into the EX/MEM latch, runs the data-cache request handshake, and drives the MEM/WB latch.
- Exports the forwarding source (destination register, write flag, data) that the forwarding unit turns into srcA/srcB/forData for execute.
- Asserts a stall to the upstream latches while a data access is outstanding.

Parameters:
- WORD_W, 32, datapath width (must match word_t)
- REG_W, 5, register index width (must match regbits_t)

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- ihit  in  1  instruction fetch done; pipeline advance request
- flush  in  1  insert bubble into EX/MEM on next advance
- ex_nPC, ex_ALUOut, ex_rtdat  in  WORD_W each  execute outputs (nPC_next, ALUOut_next, rtdat)
- ex_dREN, ex_dWEN, ex_regWr  in  1 each  execute control outputs
- ex_regSel  in  2  regsel_t writeback select
- ex_regDst  in  REG_W  destination register
- dhit  in  1  data cache done
- dmemload  in  WORD_W  load data from cache
- dmemREN, dmemWEN  out  1 each  cache request
- dmemaddr, dmemstore  out  WORD_W each  cache address / store data
- mem_stall  out  1  hold IF/ID/EX latches
- fwd_regWr  out  1  forwarding source valid
- fwd_regDst  out  REG_W  forwarding source register
- fwd_data  out  WORD_W  forwarding data
- wb_regWr  out  1  MEM/WB latch outputs
- wb_regSel  out  2  MEM/WB latch outputs
- wb_regDst  out  REG_W  MEM/WB latch outputs
- wb_ALUOut, wb_load, wb_nPC  out  WORD_W each  MEM/WB latch outputs

Behaviour:
- Reset (RST high at an edge): both latches clear to zero (bubble), FSM to IDLE, load buffer cleared. All outputs read 0 the cycle after reset. Reset wins over every other event, including mid-access.
- advance = ihit & ~mem_stall.
- mem_stall = (state == ACCESS) & ~dhit.
- EX/MEM latch:
  - On advance: loads the ex_* values.
  - If flush is also high: loads zero instead.
  - Holds otherwise.
- MEM/WB latch:
  - On advance: loads regWr/regSel/regDst/ALUOut/nPC from EX/MEM.
  - wb_load loads from dmemload if dhit this cycle, else from load buffer.
  - Holds otherwise.
- FSM states:
  - IDLE: no pending access.
  - ACCESS: request driven.
  - HOLD: access served, waiting for advance.
- State after each edge:
  - The state becomes ACCESS when the EX/MEM latch loads an instruction with dREN|dWEN = 1.
  - The state becomes IDLE when it loads anything else.
  - Both apply from any state, since loading requires advance.
  - ACCESS & dhit & ~ihit -> HOLD, capturing dmemload into the load buffer.
  - HOLD & ~advance -> HOLD.
- Request outputs:
  - dmemREN = (state == ACCESS) & latched dREN.
  - dmemWEN = (state == ACCESS) & latched dWEN.
  - Both drop combinationally in HOLD, so the cache is never re-requested after dhit.
  - dmemaddr = latched ALUOut; dmemstore = latched rtdat.
- Simultaneous dhit & ihit in ACCESS: advance occurs that edge with no HOLD cycle; the load data goes straight to wb_load.
- flush during ACCESS without dhit: advance is blocked, so the access completes first. flush is consumed on the advance that follows.
- Forwarding outputs (combinational):
  - fwd_regWr = latched regWr; fwd_regDst = latched regDst.
  - fwd_data: load data (dmemload in ACCESS with dhit, buffer in HOLD) when latched dREN; otherwise latched ALUOut.
  - fwd_regWr is forced 0 when regDst = 0.
- Latency: one cycle EX->MEM and one cycle MEM->WB per advance, plus cache wait cycles.

Decomposition:
- word_t, regbits_t, regsel_t and the mem_state_t enum (IDLE, ACCESS, HOLD) live in cpu_types_pkg and control_unit_pkg.
- New interface mem_if carries this port set with modports mem/wb/fu.
- One natural sub-module: pipe_latch, a generic enable/flush register, instantiated for EX/MEM and MEM/WB.

Test Plan:
- Reset: assert RST 2 cycles mid-ACCESS -> next cycle dmemREN = 0, mem_stall = 0, all wb_* = 0, state IDLE.
- ALU pass-through: ex_ALUOut = 0x0000_00FF, regWr = 1, regDst = 8, ihit every cycle -> fwd_data = 0xFF one cycle later; wb_ALUOut = 0xFF, wb_regDst = 8 two cycles later; dmemREN never high.
- Load with 3-cycle dhit delay: ex_dREN = 1, ALUOut = 0x100, dhit on the 3rd access cycle with dmemload = 0xDEADBEEF -> dmemaddr = 0x100; mem_stall high 2 cycles; wb_load = 0xDEADBEEF after advance.
- dhit without ihit: dhit while ihit = 0 -> state HOLD, dmemREN drops next cycle, fwd_data = buffered 0xDEADBEEF, no second request; latch advances on the next ihit.
- Store plus flush: ex_dWEN = 1, rtdat = 0x1234, flush raised during ACCESS -> dmemWEN held until dhit with dmemstore = 0x1234; the next latched entry is a bubble (wb_regWr = 0 on the following advance).
- $zero destination: regWr = 1, regDst = 0 -> fwd_regWr = 0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types for the memory stage: datapath words, register indices,
// pipeline-latch payloads and the data-access FSM states.
package mem_stage_pkg;

  localparam int unsigned WORD_BITS = 32;
  localparam int unsigned REG_BITS  = 5;

  typedef logic [WORD_BITS-1:0] word_t;
  typedef logic [REG_BITS-1:0]  regbits_t;
  typedef logic [1:0]           regsel_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    HOLD
  } mem_state_t;

  typedef struct packed {
    word_t    npc;
    word_t    alu_out;
    word_t    rtdat;
    logic     dren;
    logic     dwen;
    logic     reg_wr;
    regsel_t  reg_sel;
    regbits_t reg_dst;
  } exmem_t;

  typedef struct packed {
    logic     reg_wr;
    regsel_t  reg_sel;
    regbits_t reg_dst;
    word_t    alu_out;
    word_t    load;
    word_t    npc;
  } memwb_t;

endpackage

// File: rtl/mem_stage_pipe_latch.sv
// Generic pipeline register: loads on enable, loads zero (bubble) when
// flush accompanies the enable, holds otherwise.
module pipe_latch #(
  parameter int unsigned W = 1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         en,
  input  logic         flush,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge CLK) begin
    if (RST)
      q <= '0;
    else if (en)
      q <= flush ? '0 : d;
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: EX/MEM latch, data-cache request handshake, MEM/WB latch,
// forwarding source and upstream stall.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned REG_W  = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ihit,
  input  logic              flush,
  input  logic [WORD_W-1:0] ex_nPC,
  input  logic [WORD_W-1:0] ex_ALUOut,
  input  logic [WORD_W-1:0] ex_rtdat,
  input  logic              ex_dREN,
  input  logic              ex_dWEN,
  input  logic              ex_regWr,
  input  logic [1:0]        ex_regSel,
  input  logic [REG_W-1:0]  ex_regDst,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic              mem_stall,
  output logic              fwd_regWr,
  output logic [REG_W-1:0]  fwd_regDst,
  output logic [WORD_W-1:0] fwd_data,
  output logic              wb_regWr,
  output logic [1:0]        wb_regSel,
  output logic [REG_W-1:0]  wb_regDst,
  output logic [WORD_W-1:0] wb_ALUOut,
  output logic [WORD_W-1:0] wb_load,
  output logic [WORD_W-1:0] wb_nPC
);

  mem_state_t state_q, state_d;
  word_t      load_buf;
  exmem_t     ex_in, em;
  memwb_t     wb_in, wb;
  logic       advance;
  logic       in_access;
  word_t      load_data;

  assign in_access = (state_q == ACCESS);
  assign mem_stall = in_access & ~dhit;
  assign advance   = ihit & ~mem_stall;

  always_comb begin
    ex_in         = '0;
    ex_in.npc     = ex_nPC;
    ex_in.alu_out = ex_ALUOut;
    ex_in.rtdat   = ex_rtdat;
    ex_in.dren    = ex_dREN;
    ex_in.dwen    = ex_dWEN;
    ex_in.reg_wr  = ex_regWr;
    ex_in.reg_sel = ex_regSel;
    ex_in.reg_dst = ex_regDst;
  end

  pipe_latch #(.W($bits(exmem_t))) u_exmem (
    .CLK   (CLK),
    .RST   (RST),
    .en    (advance),
    .flush (flush),
    .d     (ex_in),
    .q     (em)
  );

  always_comb begin
    wb_in         = '0;
    wb_in.reg_wr  = em.reg_wr;
    wb_in.reg_sel = em.reg_sel;
    wb_in.reg_dst = em.reg_dst;
    wb_in.alu_out = em.alu_out;
    wb_in.load    = dhit ? dmemload : load_buf;
    wb_in.npc     = em.npc;
  end

  pipe_latch #(.W($bits(memwb_t))) u_memwb (
    .CLK   (CLK),
    .RST   (RST),
    .en    (advance),
    .flush (1'b0),
    .d     (wb_in),
    .q     (wb)
  );

  // Any advance reloads EX/MEM, so it alone decides the next state; only a
  // served access that cannot advance parks in HOLD.
  always_comb begin
    state_d = state_q;
    if (advance)
      state_d = (~flush & (ex_dREN | ex_dWEN)) ? ACCESS : IDLE;
    else if (in_access & dhit)
      state_d = HOLD;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      load_buf <= '0;
    end else begin
      state_q <= state_d;
      if (in_access & dhit & ~ihit)
        load_buf <= dmemload;
    end
  end

  assign dmemREN   = in_access & em.dren;
  assign dmemWEN   = in_access & em.dwen;
  assign dmemaddr  = em.alu_out;
  assign dmemstore = em.rtdat;

  assign load_data  = (in_access & dhit) ? dmemload : load_buf;
  assign fwd_regWr  = em.reg_wr & (em.reg_dst != '0);
  assign fwd_regDst = em.reg_dst;
  assign fwd_data   = em.dren ? load_data : em.alu_out;

  assign wb_regWr  = wb.reg_wr;
  assign wb_regSel = wb.reg_sel;
  assign wb_regDst = wb.reg_dst;
  assign wb_ALUOut = wb.alu_out;
  assign wb_load   = wb.load;
  assign wb_nPC    = wb.npc;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a transaction-level model predicts every
// output each cycle; a monitor on the opposite edge pops and compares.
module tb_mem_stage;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ihit = 1'b0, flush = 1'b0, dhit = 1'b0;
  logic        ex_dREN = 1'b0, ex_dWEN = 1'b0, ex_regWr = 1'b0;
  logic [31:0] ex_nPC = '0, ex_ALUOut = '0, ex_rtdat = '0, dmemload = '0;
  logic [1:0]  ex_regSel = '0;
  logic [4:0]  ex_regDst = '0;

  logic        dmemREN, dmemWEN, mem_stall, fwd_regWr, wb_regWr;
  logic [31:0] dmemaddr, dmemstore, fwd_data, wb_ALUOut, wb_load, wb_nPC;
  logic [4:0]  fwd_regDst, wb_regDst;
  logic [1:0]  wb_regSel;

  mem_stage #(.WORD_W(32), .REG_W(5)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .flush(flush),
    .ex_nPC(ex_nPC), .ex_ALUOut(ex_ALUOut), .ex_rtdat(ex_rtdat),
    .ex_dREN(ex_dREN), .ex_dWEN(ex_dWEN), .ex_regWr(ex_regWr),
    .ex_regSel(ex_regSel), .ex_regDst(ex_regDst),
    .dhit(dhit), .dmemload(dmemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .mem_stall(mem_stall), .fwd_regWr(fwd_regWr), .fwd_regDst(fwd_regDst), .fwd_data(fwd_data),
    .wb_regWr(wb_regWr), .wb_regSel(wb_regSel), .wb_regDst(wb_regDst),
    .wb_ALUOut(wb_ALUOut), .wb_load(wb_load), .wb_nPC(wb_nPC)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit rd; bit wr; bit rw; bit [1:0] sel; bit [4:0] dst;
    bit [31:0] npc; bit [31:0] alu; bit [31:0] rt;
  } instr_t;

  typedef struct {
    bit rw; bit [1:0] sel; bit [4:0] dst;
    bit [31:0] alu; bit [31:0] load; bit [31:0] npc;
  } wbrec_t;

  typedef struct {
    bit ren; bit wen; bit stall; bit fwr; bit fchk; bit [4:0] fdst;
    bit [31:0] addr; bit [31:0] store; bit [31:0] fdata; wbrec_t wb;
  } exp_t;

  // Model: the instruction occupying the memory slot, whether its cache
  // access has been served, the captured load word, and the writeback record.
  instr_t slot;
  bit     served;
  bit [31:0] ld_buf;
  wbrec_t wbm;
  exp_t   sb[$];
  int     checks = 0;
  int     failures = 0;

  bit s_rst, s_ihit, s_flush, s_dhit;
  bit [31:0] s_load;
  instr_t s_ex;

  function automatic bit pending();
    return (slot.rd || slot.wr) && !served;
  endfunction

  task automatic model_edge();
    bit adv;
    adv = ihit && !(pending() && !dhit);
    if (RST) begin
      slot = '{default: 0}; served = 0; ld_buf = 0; wbm = '{default: 0};
    end else if (adv) begin
      wbm.rw = slot.rw; wbm.sel = slot.sel; wbm.dst = slot.dst;
      wbm.alu = slot.alu; wbm.npc = slot.npc;
      wbm.load = dhit ? dmemload : ld_buf;
      if (flush) slot = '{default: 0};
      else slot = s_ex;
      served = 0;
    end else if (pending() && dhit) begin
      served = 1;
      ld_buf = dmemload;
    end
  endtask

  task automatic apply();
    exp_t e;
    bit   p;
    p = pending();
    RST = s_rst; ihit = s_ihit; flush = s_flush;
    dhit = s_dhit && p; dmemload = s_load;
    ex_dREN = s_ex.rd; ex_dWEN = s_ex.wr; ex_regWr = s_ex.rw;
    ex_regSel = s_ex.sel; ex_regDst = s_ex.dst;
    ex_nPC = s_ex.npc; ex_ALUOut = s_ex.alu; ex_rtdat = s_ex.rt;
    e.ren   = p && slot.rd;
    e.wen   = p && slot.wr;
    e.stall = p && !dhit;
    e.addr  = slot.alu;
    e.store = slot.rt;
    e.fwr   = slot.rw && (slot.dst != 0);
    e.fdst  = slot.dst;
    e.fchk  = !(slot.rd && p && !dhit);
    e.fdata = slot.rd ? (p ? dmemload : ld_buf) : slot.alu;
    e.wb    = wbm;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    model_edge();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("dmemREN", {31'b0, dmemREN}, {31'b0, e.ren});
        chk("dmemWEN", {31'b0, dmemWEN}, {31'b0, e.wen});
        chk("mem_stall", {31'b0, mem_stall}, {31'b0, e.stall});
        chk("dmemaddr", dmemaddr, e.addr);
        chk("dmemstore", dmemstore, e.store);
        chk("fwd_regWr", {31'b0, fwd_regWr}, {31'b0, e.fwr});
        chk("fwd_regDst", {27'b0, fwd_regDst}, {27'b0, e.fdst});
        if (e.fchk) chk("fwd_data", fwd_data, e.fdata);
        chk("wb_regWr", {31'b0, wb_regWr}, {31'b0, e.wb.rw});
        chk("wb_regSel", {30'b0, wb_regSel}, {30'b0, e.wb.sel});
        chk("wb_regDst", {27'b0, wb_regDst}, {27'b0, e.wb.dst});
        chk("wb_ALUOut", wb_ALUOut, e.wb.alu);
        chk("wb_load", wb_load, e.wb.load);
        chk("wb_nPC", wb_nPC, e.wb.npc);
      end
    end
  end

  task automatic rand_instr();
    int r;
    r = $urandom_range(0, 3);
    s_ex.rd  = (r == 0);
    s_ex.wr  = (r == 1);
    s_ex.rw  = 1'($urandom_range(0, 1));
    s_ex.sel = 2'($urandom_range(0, 3));
    s_ex.dst = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    s_ex.npc = $urandom;
    s_ex.alu = $urandom;
    s_ex.rt  = $urandom;
  endtask

  initial begin : stimulus
    slot = '{default: 0}; served = 0; ld_buf = 0; wbm = '{default: 0};
    s_rst = 0; s_ihit = 1; s_flush = 0; s_dhit = 0; s_load = 0;
    s_ex = '{default: 0};
    repeat (2) @(posedge CLK);
    #1;

    // ALU pass-through to $8
    s_ex.rw = 1; s_ex.dst = 8; s_ex.alu = 32'hFF; s_ex.npc = 32'h4;
    apply();
    s_ex = '{default: 0};
    apply(); apply();

    // load with dhit on the third access cycle
    s_ex.rd = 1; s_ex.rw = 1; s_ex.dst = 3; s_ex.alu = 32'h100;
    apply();
    s_ex = '{default: 0};
    apply(); apply();
    s_dhit = 1; s_load = 32'hDEADBEEF;
    apply();
    s_dhit = 0; s_load = 0;
    apply(); apply();

    // dhit while ihit is low parks the served load
    s_ex.rd = 1; s_ex.rw = 1; s_ex.dst = 9; s_ex.alu = 32'h200;
    apply();
    s_ex = '{default: 0}; s_ihit = 0; s_dhit = 1; s_load = 32'hDEADBEEF;
    apply();
    s_dhit = 0; s_load = 32'h0BAD0BAD;
    apply(); apply();
    s_ihit = 1;
    apply(); apply();

    // store with flush raised during the access
    s_ex.wr = 1; s_ex.rt = 32'h1234; s_ex.alu = 32'h300;
    apply();
    s_ex = '{default: 0}; s_ex.rw = 1; s_ex.dst = 5; s_ex.alu = 32'h55; s_flush = 1;
    apply(); apply();
    s_dhit = 1;
    apply();
    s_dhit = 0; s_flush = 0; s_ex = '{default: 0};
    apply(); apply();

    // write to $zero is not a forwarding source
    s_ex.rw = 1; s_ex.dst = 0; s_ex.alu = 32'h7;
    apply();
    s_ex = '{default: 0};
    apply(); apply();

    // reset held two cycles in the middle of an access
    s_ex.rd = 1; s_ex.rw = 1; s_ex.dst = 4; s_ex.alu = 32'h400;
    apply();
    s_ex = '{default: 0};
    apply();
    s_rst = 1;
    apply(); apply();
    s_rst = 0;
    apply(); apply();

    for (int i = 0; i < 3000; i++) begin
      s_rst   = ($urandom_range(0, 299) == 0);
      s_ihit  = ($urandom_range(0, 3) != 0);
      s_flush = ($urandom_range(0, 7) == 0);
      s_dhit  = ($urandom_range(0, 2) == 0);
      s_load  = $urandom;
      rand_instr();
      apply();
    end

    s_rst = 0; s_ihit = 1; s_flush = 0; s_dhit = 1; s_ex = '{default: 0};
    apply(); apply();
    repeat (3) @(negedge CLK);
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
